ioctl_ram_loader: RTL and testbench

- Sits directly downstream of the ARM→FPGA download port (ioctl_*). Packs the incoming byte stream into 16-bit words with byte enables and buffers them in a small FIFO.
- Issues one write per word to the core's memory controller using a req/ack handshake.
- Throttles the upstream download by driving ioctl_ce low when the buffer nears full.
- Used to load ROM and RAM images for a selected menu index into SDRAM or BRAM.

---
 rtl/ioctl_loader_pkg.sv | 22 ++
 rtl/ioctl_ram_loader_if.sv | 27 ++
 rtl/ioctl_word_fifo.sv | 60 ++++++
 rtl/ioctl_ram_loader.sv | 168 ++++++++++++++++
 tb/tb_ioctl_ram_loader.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ioctl_loader_pkg.sv
// Shared types for the ioctl download-to-memory loader.
// Word entries carry a word address, 16-bit data and byte enables.
package ioctl_loader_pkg;

  localparam int WADDR_W = 24;

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

  typedef struct packed {
    logic [WADDR_W-1:0] waddr;
    logic [15:0]        data;
    logic [1:0]         be;
  } word_entry_t;

  function automatic int fifo_depth(input int log2);
    return 1 << log2;
  endfunction

endpackage

// File: rtl/ioctl_ram_loader_if.sv
// Memory write port of the loader: level request, one-cycle ack.
// The loader drives the master side, the memory controller the slave.
interface ioctl_ram_loader_if #(
  parameter int ADDR_W = 24
);
  logic              mem_req;
  logic              mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_din;
  logic [1:0]        mem_be;

  modport master (
    output mem_req,
    output mem_addr,
    output mem_din,
    output mem_be,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    input  mem_din,
    input  mem_be,
    output mem_ack
  );
endinterface

// File: rtl/ioctl_word_fifo.sv
// Small synchronous FIFO of word entries, first-word fall-through.
// Push and pop in the same cycle leave the count unchanged.
module ioctl_word_fifo
  import ioctl_loader_pkg::*;
#(
  parameter int LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  word_entry_t din,
  input  logic        pop,
  output word_entry_t dout,
  output logic [LOG2:0] count,
  output logic        empty,
  output logic        full
);

  localparam int D = fifo_depth(LOG2);

  word_entry_t       mem_q [D];
  logic [LOG2-1:0]   wp_q;
  logic [LOG2-1:0]   rp_q;
  logic [LOG2:0]     cnt_q;
  logic              do_pop;

  assign do_pop = pop && !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wp_q] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        wp_q <= wp_q + 1'b1;
      end
      if (do_pop) begin
        rp_q <= rp_q + 1'b1;
      end
      unique case ({push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign dout  = mem_q[rp_q];
  assign count = cnt_q;
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (LOG2+1)'(D));

endmodule

// File: rtl/ioctl_ram_loader.sv
// Packs the ioctl byte stream into 16-bit words with byte enables,
// buffers them and writes them out through a req/ack memory port.
module ioctl_ram_loader
  import ioctl_loader_pkg::*;
#(
  parameter int               ADDR_W      = WADDR_W,
  parameter logic [ADDR_W-1:0] BASE_WADDR = '0,
  parameter logic [7:0]       INDEX_MATCH = 8'h00,
  parameter int               FIFO_LOG2   = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_ce,
  ioctl_ram_loader_if.master mem,
  output logic        busy,
  output logic        done,
  output logic [24:0] byte_count
);

  localparam int D = fifo_depth(FIFO_LOG2);

  logic        active, accept, rise, fall, odd;
  logic        ce_q, dl_q;
  logic        hv_q, hv_d;
  word_entry_t hold_q, hold_d;
  word_entry_t nb, merged, push_e, head;
  logic        push, push_ok, pop;
  logic [FIFO_LOG2:0] fcount;
  logic        fempty, ffull;
  state_t      st_q, st_d;
  logic        req_q, req_d;
  word_entry_t out_q, out_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [24:0] bc_q, bc_d;
  logic [ADDR_W-1:0] waddr_in;

  assign active   = ioctl_download && (ioctl_index == INDEX_MATCH);
  assign accept   = ioctl_wr && ce_q && active;
  assign rise     = active && !dl_q;
  assign fall     = !active && dl_q;
  assign odd      = ioctl_addr[0];
  assign waddr_in = BASE_WADDR + ADDR_W'(ioctl_addr[24:1]);
  // Leaves room for one accept push plus one end-of-load push.
  assign ioctl_ce = (fcount <= (FIFO_LOG2+1)'(D-2));

  always_comb begin
    nb.waddr = waddr_in;
    nb.data  = odd ? {ioctl_dout, 8'h00} : {8'h00, ioctl_dout};
    nb.be    = odd ? 2'b10 : 2'b01;
    merged   = hold_q;
    if (odd) begin
      merged.data[15:8] = ioctl_dout;
      merged.be[1]      = 1'b1;
    end else begin
      merged.data[7:0]  = ioctl_dout;
      merged.be[0]      = 1'b1;
    end
  end

  always_comb begin
    hv_d   = hv_q;
    hold_d = hold_q;
    push   = 1'b0;
    push_e = hold_q;
    if (accept) begin
      if (hv_q && hold_q.waddr == waddr_in) begin
        push   = 1'b1;
        push_e = merged;
        hv_d   = 1'b0;
      end else begin
        push   = hv_q;
        hold_d = nb;
        hv_d   = 1'b1;
      end
    end else if (fall && hv_q) begin
      push = 1'b1;
      hv_d = 1'b0;
    end
  end

  assign push_ok = push && !ffull;

  ioctl_word_fifo #(
    .LOG2 (FIFO_LOG2)
  ) u_fifo (
    .clk   (clk_sys),
    .rst   (reset),
    .push  (push_ok),
    .din   (push_e),
    .pop   (pop),
    .dout  (head),
    .count (fcount),
    .empty (fempty),
    .full  (ffull)
  );

  always_comb begin
    st_d  = st_q;
    req_d = req_q;
    out_d = out_q;
    pop   = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (!fempty) begin
          out_d = head;
          req_d = 1'b1;
          st_d  = REQ;
        end
      end
      REQ: begin
        if (mem.mem_ack) begin
          pop   = 1'b1;
          req_d = 1'b0;
          st_d  = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    done_d = !active && !hv_q && fempty
             && (st_q == IDLE) && busy_q;
    busy_d = rise ? 1'b1 : (done_d ? 1'b0 : busy_q);
    bc_d   = (rise ? 25'd0 : bc_q) + 25'(accept);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ce_q   <= 1'b1;
      dl_q   <= 1'b0;
      hv_q   <= 1'b0;
      hold_q <= '0;
      st_q   <= IDLE;
      req_q  <= 1'b0;
      out_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      bc_q   <= '0;
    end else begin
      ce_q   <= ioctl_ce;
      dl_q   <= active;
      hv_q   <= hv_d;
      hold_q <= hold_d;
      st_q   <= st_d;
      req_q  <= req_d;
      out_q  <= out_d;
      busy_q <= busy_d;
      done_q <= done_d;
      bc_q   <= bc_d;
    end
  end

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = out_q.waddr;
  assign mem.mem_din  = out_q.data;
  assign mem.mem_be   = out_q.be;
  assign busy         = busy_q;
  assign done         = done_q;
  assign byte_count   = bc_q;

endmodule

// File: tb/tb_ioctl_ram_loader.sv
// Directed bench for ioctl_ram_loader with a req/ack memory responder.
// Expected memory writes are hand-computed constants per scenario.
module tb_ioctl_ram_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_ce;
  logic        busy, done;
  logic [24:0] byte_count;

  int vec  = 0;
  int miss = 0;
  int ack_delay = 1;
  int done_cnt = 0;
  int wr_at_done = 0;
  int req_cycles = 0;
  int overflow = 0;
  bit ce_low_seen = 0;

  logic [23:0] wq_addr [$];
  logic [15:0] wq_din  [$];
  logic [1:0]  wq_be   [$];

  always #5 clk = ~clk;

  ioctl_ram_loader_if #(.ADDR_W(24)) mem_bus ();

  ioctl_ram_loader dut (
    .clk_sys        (clk),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_ce       (ioctl_ce),
    .mem            (mem_bus),
    .busy           (busy),
    .done           (done),
    .byte_count     (byte_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] bmask(input logic [1:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction

  initial begin
    mem_bus.mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_bus.mem_req && !reset) begin
        int k;
        k = 1;
        while (k < ack_delay && mem_bus.mem_req) begin
          @(negedge clk);
          k++;
        end
        if (mem_bus.mem_req && !reset) begin
          mem_bus.mem_ack = 1'b1;
          wq_addr.push_back(mem_bus.mem_addr);
          wq_din.push_back(mem_bus.mem_din);
          wq_be.push_back(mem_bus.mem_be);
          @(negedge clk);
          mem_bus.mem_ack = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      wr_at_done = wq_addr.size();
    end
    if (!ioctl_ce) ce_low_seen = 1'b1;
    if (mem_bus.mem_req) req_cycles++;
    if (dut.push && dut.ffull) overflow++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_q();
    wq_addr.delete();
    wq_din.delete();
    wq_be.delete();
  endtask

  task automatic start_load(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick(1);
  endtask

  task automatic send(input logic [24:0] a, input logic [7:0] d);
    logic [24:0] bc0;
    int n;
    bc0        = byte_count;
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (byte_count == bc0 && n < 400);
    ioctl_wr = 1'b0;
    if (byte_count == bc0) chk("accept_timeout", byte_count, bc0 + 25'd1);
  endtask

  task automatic end_load(input int target, input int limit);
    int n;
    ioctl_download = 1'b0;
    n = 0;
    while (done_cnt < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    tick(4);
    chk("done_pulses", done_cnt, target);
  endtask

  task automatic chk_wr(input int i, input logic [23:0] a,
                        input logic [15:0] d, input logic [1:0] be);
    chk($sformatf("wr%0d_addr", i), wq_addr[i], a);
    chk($sformatf("wr%0d_be", i), wq_be[i], be);
    chk($sformatf("wr%0d_din", i), wq_din[i] & bmask(be), d & bmask(be));
  endtask

  initial begin
    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index = 8'h00;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("rst_ce", ioctl_ce, 1);
    chk("rst_req", mem_bus.mem_req, 0);
    chk("rst_addr", mem_bus.mem_addr, 0);
    chk("rst_din", mem_bus.mem_din, 0);
    chk("rst_be", mem_bus.mem_be, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bc", byte_count, 0);

    // non-matching index: bytes ignored
    req_cycles = 0;
    start_load(8'h01);
    for (int i = 0; i < 4; i++) begin
      ioctl_addr = 25'(i);
      ioctl_dout = 8'(8'h11 * (i + 1));
      ioctl_wr = 1'b1;
      tick(1);
    end
    ioctl_wr = 1'b0;
    tick(20);
    chk("idx_req", req_cycles, 0);
    chk("idx_bc", byte_count, 0);
    chk("idx_busy", busy, 0);
    chk("idx_ce", ioctl_ce, 1);
    ioctl_download = 1'b0;
    tick(5);
    chk("idx_done", done_cnt, 0);
    chk("idx_writes", wq_addr.size(), 0);

    // four aligned bytes
    ack_delay = 1;
    clear_q();
    start_load(8'h00);
    chk("t1_busy", busy, 1);
    send(25'h0, 8'h11);
    send(25'h1, 8'h22);
    send(25'h2, 8'h33);
    send(25'h3, 8'h44);
    end_load(1, 200);
    chk("t1_nwr", wq_addr.size(), 2);
    chk_wr(0, 24'h0, 16'h2211, 2'b11);
    chk_wr(1, 24'h1, 16'h4433, 2'b11);
    chk("t1_bc", byte_count, 4);
    chk("t1_busy_end", busy, 0);

    // three bytes, partial word flushed at end
    clear_q();
    start_load(8'h00);
    send(25'h10, 8'hA1);
    send(25'h11, 8'hB2);
    send(25'h12, 8'hC3);
    end_load(2, 200);
    chk("t2_nwr", wq_addr.size(), 2);
    chk_wr(0, 24'h8, 16'hB2A1, 2'b11);
    chk_wr(1, 24'h9, 16'h00C3, 2'b01);
    chk("t2_done_after_ack", wr_at_done, 2);
    chk("t2_bc", byte_count, 3);

    // odd start and address jump
    clear_q();
    start_load(8'h00);
    send(25'h5, 8'h55);
    send(25'h8, 8'h88);
    end_load(3, 200);
    chk("t3_nwr", wq_addr.size(), 2);
    chk_wr(0, 24'h2, 16'h5500, 2'b10);
    chk_wr(1, 24'h4, 16'h0088, 2'b01);

    // 16-byte burst against a slow memory
    clear_q();
    ack_delay = 50;
    ce_low_seen = 1'b0;
    start_load(8'h00);
    for (int i = 0; i < 16; i++) send(25'(32 + i), 8'(64 + i));
    end_load(4, 3000);
    chk("t4_ce_low", ce_low_seen, 1);
    chk("t4_nwr", wq_addr.size(), 8);
    for (int k = 0; k < 8; k++)
      chk_wr(k, 24'(16 + k), {8'(64 + 2*k + 1), 8'(64 + 2*k)}, 2'b11);
    chk("t4_bc", byte_count, 16);

    // reset while a write is outstanding
    clear_q();
    start_load(8'h00);
    send(25'h40, 8'h01);
    send(25'h41, 8'h02);
    send(25'h42, 8'h03);
    for (int n = 0; n < 200 && !mem_bus.mem_req; n++) tick(1);
    chk("t5_req_pre", mem_bus.mem_req, 1);
    reset = 1'b1;
    ioctl_download = 1'b0;
    tick(1);
    chk("t5_req", mem_bus.mem_req, 0);
    chk("t5_ce", ioctl_ce, 1);
    chk("t5_busy", busy, 0);
    chk("t5_bc", byte_count, 0);
    reset = 1'b0;
    ack_delay = 1;
    tick(2);
    clear_q();
    start_load(8'h00);
    send(25'h40, 8'h5A);
    send(25'h41, 8'hA5);
    send(25'h42, 8'h3C);
    send(25'h43, 8'hC3);
    end_load(5, 200);
    chk("t5_nwr", wq_addr.size(), 2);
    chk_wr(0, 24'h20, 16'hA55A, 2'b11);
    chk_wr(1, 24'h21, 16'hC33C, 2'b11);
    chk("fifo_overflow", overflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
